// File: rtl/sa_feeder.sv
// rtl/sa_feeder.sv - skewed operand feeder for the float16 systolic array
// Captures one k-step per beat and staggers lane i by i cycles into DVI/DI.
module sa_feeder #(
    parameter int DIMENSION = 4,
    parameter bit SERIALIZE = 1'b0
) (
    input  logic                                 CLK,
    input  logic                                 RSTn,
    input  logic                                 S_VALID,
    output logic                                 S_READY,
    input  logic                                 S_LAST,
    input  logic [DIMENSION-1:0][15:0]           S_A,
    input  logic [DIMENSION-1:0][15:0]           S_B,
    output logic [DIMENSION-1:0]                 DVI,
    output logic [1:0][DIMENSION-1:0][15:0]      DI,
    output logic                                 TILE_DONE,
    output logic                                 BUSY,
    output logic                                 ERR,
    input  logic                                 ERR_CLR
);

    localparam int CW = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t               state_q, state_d;
    logic                 ready_q, ready_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [DIMENSION-1:0] v_q, v_d;
    logic [DIMENSION-1:0] l_q, l_d;

    logic accept;
    logic at_end;
    logic tile_end;
    logic tile_done;

    assign accept    = S_VALID && ready_q;
    assign at_end    = (cnt_q == CW'(DIMENSION - 1));
    assign tile_end  = accept && (S_LAST || at_end);
    assign tile_done = v_q[DIMENSION-1] && l_q[DIMENSION-1];

    always_comb begin
        v_d    = '0;
        l_d    = '0;
        v_d[0] = accept;
        l_d[0] = tile_end;
        for (int s = 1; s < DIMENSION; s++) begin
            v_d[s] = v_q[s-1];
            l_d[s] = l_q[s-1];
        end

        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = tile_end ? '0 : cnt_q + CW'(1);
        end

        // A clear wins over a framing error seen in the same cycle.
        err_d = ERR_CLR ? 1'b0 : (err_q | (accept && (S_LAST != at_end)));

        state_d = state_q;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (tile_end) state_d = SERIALIZE ? FLUSH : IDLE;
                    else          state_d = STREAM;
                end
            end
            FLUSH: begin
                if (tile_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d != FLUSH);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            v_q     <= '0;
            l_q     <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            v_q     <= v_d;
            l_q     <= l_d;
        end
    end

    // Each lane keeps only the i+1 data stages it actually needs.
    for (genvar i = 0; i < DIMENSION; i++) begin : g_lane
        logic [i:0][15:0] a_q, a_d, b_q, b_d;

        always_comb begin
            a_d    = '0;
            b_d    = '0;
            a_d[0] = accept ? S_A[i] : 16'h0000;
            b_d[0] = accept ? S_B[i] : 16'h0000;
            for (int s = 1; s <= i; s++) begin
                a_d[s] = a_q[s-1];
                b_d[s] = b_q[s-1];
            end
        end

        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                a_q <= '0;
                b_q <= '0;
            end else begin
                a_q <= a_d;
                b_q <= b_d;
            end
        end

        assign DI[0][i] = a_q[i];
        assign DI[1][i] = b_q[i];
    end

    assign DVI       = v_q;
    assign S_READY   = ready_q;
    assign TILE_DONE = tile_done;
    assign BUSY      = (cnt_q != '0) || (|v_q) || (state_q == FLUSH);
    assign ERR       = err_q;

endmodule

// File: tb/tb_sa_feeder.sv
// tb/tb_sa_feeder.sv - self-checking bench for sa_feeder
// Beat-history reference model for the streaming instance plus directed checks for serialization.
module tb_sa_feeder;

    localparam int D = 4;

    typedef struct {
        logic                 v;
        logic                 tend;
        logic [D-1:0][15:0]   a;
        logic [D-1:0][15:0]   b;
    } beat_t;

    logic clk;
    logic rst_n;

    logic                         s_valid, s_last, err_clr;
    logic [D-1:0][15:0]           s_a, s_b;
    logic                         s_ready, tile_done, busy, err;
    logic [D-1:0]                 dvi;
    logic [1:0][D-1:0][15:0]      di;

    logic                         s1_valid, s1_last, err_clr1;
    logic                         s1_ready, tile_done1, busy1, err1;
    logic [D-1:0]                 dvi1;
    logic [1:0][D-1:0][15:0]      di1;

    int n_assert = 0;
    int n_fail   = 0;

    beat_t hist[$];
    int    mcnt;
    logic  merr;

    sa_feeder #(.DIMENSION(D), .SERIALIZE(1'b0)) dut (
        .CLK(clk), .RSTn(rst_n), .S_VALID(s_valid), .S_READY(s_ready), .S_LAST(s_last),
        .S_A(s_a), .S_B(s_b), .DVI(dvi), .DI(di), .TILE_DONE(tile_done), .BUSY(busy),
        .ERR(err), .ERR_CLR(err_clr)
    );

    sa_feeder #(.DIMENSION(D), .SERIALIZE(1'b1)) dut_ser (
        .CLK(clk), .RSTn(rst_n), .S_VALID(s1_valid), .S_READY(s1_ready), .S_LAST(s1_last),
        .S_A(s_a), .S_B(s_b), .DVI(dvi1), .DI(di1), .TILE_DONE(tile_done1), .BUSY(busy1),
        .ERR(err1), .ERR_CLR(err_clr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        beat_t z;
        z.v = 1'b0; z.tend = 1'b0; z.a = '0; z.b = '0;
        hist.delete();
        for (int i = 0; i < D; i++) hist.push_back(z);
        mcnt = 0;
        merr = 1'b0;
    endtask

    task automatic check_all();
        logic any_v;
        any_v = 1'b0;
        for (int i = 0; i < D; i++) begin
            chk($sformatf("dvi[%0d]", i), dvi[i], hist[i].v);
            chk($sformatf("di_a[%0d]", i), di[0][i], hist[i].a[i]);
            chk($sformatf("di_b[%0d]", i), di[1][i], hist[i].b[i]);
            any_v = any_v | hist[i].v;
        end
        chk("tile_done", tile_done, hist[D-1].tend);
        chk("busy", busy, (mcnt != 0) || any_v);
        chk("err", err, merr);
        chk("s_ready", s_ready, 1'b1);
    endtask

    // One clock: fold the presented inputs into the model, advance, then check.
    task automatic step();
        beat_t nb;
        logic  at_end;
        logic  eset;
        at_end  = (mcnt == D - 1);
        eset    = 1'b0;
        nb.v    = s_valid;
        nb.tend = s_valid && (s_last || at_end);
        nb.a    = s_valid ? s_a : '0;
        nb.b    = s_valid ? s_b : '0;
        if (s_valid) begin
            if (s_last != at_end) eset = 1'b1;
            mcnt = nb.tend ? 0 : mcnt + 1;
        end
        merr = err_clr ? 1'b0 : (merr | eset);
        hist.push_front(nb);
        void'(hist.pop_back());
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic last, input logic clr);
        s_valid = v;
        s_last  = last;
        err_clr = clr;
        for (int i = 0; i < D; i++) begin
            s_a[i] = 16'($urandom);
            s_b[i] = 16'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            drive(1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n    = 1'b0;
        #1;
        model_clear();
        check_all();
        s_valid  = 1'b0;
        s1_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic k_tile();
        for (int k = 0; k < D; k++) begin
            drive(1'b1, k == D - 1, 1'b0);
            for (int i = 0; i < D; i++) begin
                s_a[i] = 16'(k);
                s_b[i] = 16'(k);
            end
            step();
        end
    endtask

    function automatic logic ser_ready(input int c);
        return !((c >= 4 && c <= 7) || (c >= 12 && c <= 15));
    endfunction

    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0; s_last = 1'b0; err_clr = 1'b0;
        s_a      = '0;   s_b    = '0;
        s1_valid = 1'b0; s1_last = 1'b0; err_clr1 = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        k_tile();
        idle(6);

        drive(1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b0); step();
        drive(1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 1'b1, 1'b0); step();
        idle(6);

        drive(1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 1'b1, 1'b0); step();
        for (int k = 0; k < D; k++) begin
            drive(1'b1, k == D - 1, 1'b0); step();
        end
        idle(5);
        drive(1'b0, 1'b0, 1'b1); step();
        drive(1'b1, 1'b1, 1'b1); step();
        idle(5);

        for (int n = 0; n < 3 * D; n++) begin
            drive(1'b1, (n % D) == D - 1, 1'b0); step();
        end
        idle(6);

        for (int c = 0; c < 80; c++) begin
            logic v, l;
            v = ($urandom_range(0, 9) < 7);
            l = (mcnt == D - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
            drive(v, l, $urandom_range(0, 15) == 0);
            step();
        end
        idle(6);

        do_reset();
        drive(1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b0);
        do_reset();
        idle(D + 1);
        k_tile();
        idle(6);

        do_reset();
        for (int t = 0; t <= 16; t++) begin
            s1_valid = 1'b1;
            s1_last  = (t == 3) || (t == 11);
            chk($sformatf("ser_ready_pre[%0d]", t), s1_ready, ser_ready(t));
            drive(1'b0, 1'b0, 1'b0);
            step();
            chk($sformatf("ser_ready[%0d]", t + 1), s1_ready, ser_ready(t + 1));
            chk($sformatf("ser_dvi0[%0d]", t + 1), dvi1[0], ser_ready(t));
            chk($sformatf("ser_tile_done[%0d]", t + 1), tile_done1, (t + 1 == 7) || (t + 1 == 15));
        end
        s1_valid = 1'b0;
        chk("ser_err", err1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_feeder.md
Name: sa_feeder

Overview:
- Source-side companion of the float16 systolic array.
- Accepts one k-step per beat over a valid/ready handshake: column k of A (one value per array row) and row k of B (one value per array column).
- Drives the array's DVI/DI inputs with the diagonal skew the array requires: lane i is delayed i cycles relative to lane 0, for both operands and valid.
- Tracks tile boundaries (DIMENSION beats per tile), flags framing errors, signals when a tile has fully entered the array, and can optionally serialize tiles.

Parameters:
- DIMENSION, 4, array size; also beats per tile, matching the MAC accumulation count.
- SERIALIZE, 1'b0, 1 = block new input after a tile's last beat until that tile has fully left the skew lines.

Ports:
- CLK  input  1  clock, rising edge
- RSTn  input  1  asynchronous active-low reset
- S_VALID  input  1  input beat valid
- S_READY  output  1  feeder can accept a beat
- S_LAST  input  1  beat is the last k-step of a tile
- S_A  input  [DIMENSION-1:0][15:0]  A[i][k], i = array row
- S_B  input  [DIMENSION-1:0][15:0]  B[k][j], j = array column
- DVI  output  [DIMENSION-1:0]  per-row valid to the array (skewed)
- DI  output  [1:0][DIMENSION-1:0][15:0]  DI[0][i] = row operand lane i, DI[1][j] = column operand lane j (skewed)
- TILE_DONE  output  1  one-cycle pulse when the tile's last beat appears on lane DIMENSION-1
- BUSY  output  1  a partial tile is open or beats are in flight
- ERR  output  1  sticky framing error
- ERR_CLR  input  1  synchronous clear of ERR

Behaviour:
- Reset (async, RSTn=0): DVI, DI, all skew registers, beat counter, TILE_DONE, ERR = 0. FSM = IDLE. S_READY = 1 after reset.
- Accept: a beat is accepted when S_VALID && S_READY at a rising edge (cycle t).
- Capture: an accepted beat is captured into lane stage 0. A non-accepted cycle captures valid=0 and data=16'h0000; invalid lanes always carry zero data.
- Skew: lane i (DVI[i], DI[0][i], DI[1][i]) outputs the stage-0 content delayed i further cycles, so a beat accepted at t appears on lane i in cycle t+1+i.
- Skew lines shift every cycle unconditionally. Input gaps propagate as DVI=0 holes on every lane, keeping A/B alignment at every PE.
- Beat counter: 0..DIMENSION-1, incremented per accepted beat.
  - Expected framing: S_LAST=1 exactly when count==DIMENSION-1.
  - On an accepted beat with S_LAST XOR (count==DIMENSION-1): set ERR; counter returns to 0 (resync on either LAST or wrap).
  - Correct last beat: counter returns to 0.
- TILE_DONE: a last-flag travels alongside DVI through DIMENSION stages. TILE_DONE=1 in cycle t+DIMENSION for a tile-ending beat (LAST or wrap) accepted at t.
- ERR: ERR_CLR has priority over a same-cycle set; ERR stays 0 for that cycle.
- FSM states and transitions:
  - IDLE -> STREAM on an accepted beat.
  - STREAM -> IDLE when the counter returns to 0 with SERIALIZE=0 (S_READY stays 1 throughout).
  - STREAM -> FLUSH on a tile-ending beat with SERIALIZE=1.
  - FLUSH: S_READY=0; exits to IDLE in the cycle after TILE_DONE. S_READY=1 again that cycle.
  - S_READY=1 in IDLE and STREAM.
- BUSY = (count!=0) | any stage valid bit set | (state==FLUSH).
- Back-to-back tiles with SERIALIZE=0: tile n+1's first beat is accepted the cycle after tile n's last beat, with no bubble.
- Reset mid-tile: every in-flight beat is discarded; no TILE_DONE is emitted for the aborted tile.

Test Plan:
- DIMENSION=4, SERIALIZE=0, 4 beats t=0..3 with S_A=S_B={k,k,k,k}, LAST on beat 3 -> DVI[i] high cycles 1+i..4+i; DI[0][2]=k in cycle 3+k; TILE_DONE only in cycle 7; ERR=0.
- Gap: beats at t=0,1,3,4 (S_VALID low at t=2) -> every lane shows the same one-cycle hole, shifted by i; DI=0 in the hole; TILE_DONE in cycle 8.
- Framing: S_LAST on beat 1 -> ERR=1 the next cycle; the following 4-beat correct tile yields TILE_DONE; ERR_CLR pulse -> ERR=0; simultaneous set+clear -> ERR stays 0.
- SERIALIZE=1: tile ends at t=3 -> S_READY=0 cycles 4..7, 1 at cycle 8; a second tile offered continuously starts acceptance at t=8.
- Back-to-back 3 tiles with SERIALIZE=0 -> TILE_DONE at 7, 11, 15; BUSY falls in cycle 16.
- RSTn asserted asynchronously mid-tile at t=2 -> DVI, DI, BUSY = 0 immediately; no TILE_DONE; after release the next full tile behaves as in scenario 1.
